// File: rtl/fetch_queue_unit_pkg.sv
// kgp_fetch_pkg: shared constants, types and helpers for the KGP-RISC fetch front end.
//   PC_STEP      : byte increment between sequential fetches
//   fetch_entry_t: {pc, instr} entry for the default 32/32 build
//   clog2        : pointer-width helper, usable in constant expressions
package kgp_fetch_pkg;

  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: bundles the instruction-memory port, the redirect port from
// execute, the decode-side instruction port and the debug occupancy count.
//   master : fetch unit view (drives imem requests, instruction outputs, q_count)
//   slave  : environment view (memory, execute and decode)
interface fetch_queue_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = kgp_fetch_pkg::clog2(DEPTH) + 1;

  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               inst_valid;
  logic [INSTR_W-1:0] inst_data;
  logic [ADDR_W-1:0]  inst_pc;
  logic               inst_ready;
  logic [CNT_W-1:0]   q_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    output q_count
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    input  q_count
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: circular prefetch buffer with wrapping pointers and an occupancy count.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : synchronous flush (wins over push/pop)
//   push_i, entry_i : write one entry at the tail
//   pop_i      : drop the head entry
//   head_o     : registered head entry; count_o: occupancy
// The caller never pushes when full and never pops when empty.
module fetch_fifo
  import kgp_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  entry_t                entry_i,
  input  logic                  pop_i,
  output entry_t                head_o,
  output logic [clog2(DEPTH):0] count_o
);
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Storage needs no reset: the head is only observed when count is nonzero.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= entry_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end for KGP-RISC. PC generator, one
// outstanding valid/ready imem request, DEPTH-entry prefetch queue, redirect flush.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch_queue_unit_if.master (imem request/response, redirect,
//                decode-side instruction port, q_count)
// Optional feature macro: FETCH_BYPASS_EN -- an unkilled response arriving at an
// empty queue is presented to decode in the same cycle.
module fetch_queue_unit
  import kgp_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  fetch_queue_unit_if.master  bus
);
  localparam int CNT_W = clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_pending_q, pc_pending_d;
  logic              pending_q, pending_d;
  logic              kill_q, kill_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    used;
  logic              req_fire, resp_ok, fifo_push, fifo_pop, fifo_empty;
  fq_entry_t         head, resp_entry, out_entry;

  // Credit: queued entries plus the one in flight must leave room for a new one.
  assign used     = {1'b0, count} + {{CNT_W{1'b0}}, pending_q};
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (used < (CNT_W+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  // Only the response to our own last-cycle request counts; a reset clears pending.
  assign resp_ok    = bus.imem_resp_valid && pending_q && !kill_q && !bus.redirect_valid;
  assign resp_entry = '{pc: pc_pending_q, instr: bus.imem_resp_data};
  assign fifo_empty = (count == '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass         = resp_ok && fifo_empty;
  assign bus.inst_valid = !bus.redirect_valid && (bypass || !fifo_empty);
  assign out_entry      = bypass ? resp_entry : head;
  assign fifo_push      = resp_ok && !(bypass && bus.inst_ready);
  assign fifo_pop       = bus.inst_valid && bus.inst_ready && !bypass;
`else
  assign bus.inst_valid = !bus.redirect_valid && !fifo_empty;
  assign out_entry      = head;
  assign fifo_push      = resp_ok;
  assign fifo_pop       = bus.inst_valid && bus.inst_ready;
`endif

  assign bus.inst_data = bus.inst_valid ? out_entry.instr : '0;
  assign bus.inst_pc   = bus.inst_valid ? out_entry.pc    : '0;
  assign bus.q_count   = count;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pc_pending_d = pc_pending_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);
    end else if (req_fire) begin
      fetch_pc_d   = fetch_pc_q + ADDR_W'(PC_STEP);
      pc_pending_d = fetch_pc_q;
    end
    pending_d = req_fire;
    kill_d    = bus.redirect_valid && pending_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      pc_pending_q <= '0;
      pending_q    <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pc_pending_q <= pc_pending_d;
      pending_q    <= pending_d;
      kill_q       <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fq_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.redirect_valid),
    .push_i  (fifo_push),
    .entry_i (resp_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset;

  fetch_queue_unit_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) bus ();
  fetch_queue_unit_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) busw ();

  fetch_queue_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_queue_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .bus(busw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  int          n_acc;
  bit          sb_en;
  logic [31:0] exp_pc;
  logic        acc, accw;
  logic [31:0] a, aw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: optional in-order pop check, then the memory model answers every
  // accepted request exactly one cycle later with data = addr >> 2.
  task automatic tick();
    #1;
    if (sb_en && bus.inst_valid && bus.inst_ready) begin
      check("sb_pc", bus.inst_pc, exp_pc);
      check("sb_data", bus.inst_data, exp_pc >> 2);
      exp_pc = exp_pc + 32'd4;
    end
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    a    = bus.imem_req_addr;
    accw = busw.imem_req_valid && busw.imem_req_ready;
    aw   = busw.imem_req_addr;
    if (acc) n_acc++;
    @(posedge clk);
    #1;
    bus.imem_resp_valid  = acc;
    bus.imem_resp_data   = a >> 2;
    busw.imem_resp_valid = accw;
    busw.imem_resp_data  = aw >> 2;
    #1;
  endtask

  initial begin
    int guard;
    n_tests = 0; n_fail = 0; n_acc = 0; sb_en = 0; exp_pc = '0;
    reset = 1'b1;
    bus.imem_req_ready = 1'b1;  bus.imem_resp_valid = 1'b0;  bus.imem_resp_data = '0;
    bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;        bus.inst_ready = 1'b1;
    busw.imem_req_ready = 1'b1; busw.imem_resp_valid = 1'b0; busw.imem_resp_data = '0;
    busw.redirect_valid = 1'b0; busw.redirect_pc = '0;       busw.inst_ready = 1'b1;
    tick(); tick();

    // Reset values
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst_data", bus.inst_data, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_q_count", 32'(bus.q_count), 32'd0);
    check("rst_w_addr", busw.imem_req_addr, 32'hFFFF_FFF8);

    // Streaming with everything ready; wrap instance runs alongside
    reset = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      check("a_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("a_req_addr", bus.imem_req_addr, 32'(4 * k));
      check("w_req_addr", busw.imem_req_addr, 32'hFFFF_FFF8 + 32'(4 * k));
      if (k >= LAT) begin
        check("a_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("a_inst_pc", bus.inst_pc, 32'(4 * (k - LAT)));
        check("a_inst_data", bus.inst_data, 32'(k - LAT));
      end else begin
        check("a_inst_idle", 32'(bus.inst_valid), 32'd0);
      end
      tick();
    end

    // Reset mid-stream with two entries queued
    bus.inst_ready = 1'b0; #1;
    tick();
    guard = 0;
    while (bus.q_count != 3'd2 && guard < 4) begin
      tick();
      guard++;
    end
    check("b_q_count_2", 32'(bus.q_count), 32'd2);
    reset = 1'b1; #1;
    check("b_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("b_req_addr", bus.imem_req_addr, 32'h0);
    check("b_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("b_inst_data", bus.inst_data, 32'h0);
    check("b_inst_pc", bus.inst_pc, 32'h0);
    check("b_q_count", 32'(bus.q_count), 32'd0);
    tick();
    reset = 1'b0; #1;
    // A late response to a pre-reset request must be ignored
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hDEAD; #1;
    check("b_stale_drop", 32'(bus.inst_valid), 32'd0);
    check("b_restart_valid", 32'(bus.imem_req_valid), 32'd1);
    check("b_restart_addr", bus.imem_req_addr, 32'h0);

    // Fill with decode stalled: exactly DEPTH requests
    n_acc = 0;
    for (int i = 0; i < 8; i++) tick();
    check("c_accepts", 32'(n_acc), 32'd4);
    check("c_q_full", 32'(bus.q_count), 32'd4);
    check("c_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    check("c_head_pc", bus.inst_pc, 32'h0);
    check("c_head_data", bus.inst_data, 32'h0);

    // Drain in order; full queue issues nothing on the first popping cycle
    bus.inst_ready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      check("c_drain_valid", 32'(bus.inst_valid), 32'd1);
      check("c_drain_pc", bus.inst_pc, 32'(4 * i));
      check("c_drain_data", bus.inst_data, 32'(i));
      if (i == 0) begin
        check("c_bubble", 32'(bus.imem_req_valid), 32'd0);
      end else begin
        check("c_req_addr", bus.imem_req_addr, 32'(16 + 4 * (i - 1)));
      end
      tick();
    end

    // Memory stall: request held stable for 3 cycles, no address skipped
    sb_en = 1; exp_pc = 32'd32;
    bus.imem_req_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("d_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      check("d_hold_addr", bus.imem_req_addr, 32'd44);
      tick();
    end
    bus.imem_req_ready = 1'b1; #1;
    check("d_resume_addr", bus.imem_req_addr, 32'd44);
    for (int i = 0; i < 10; i++) tick();
    check("d_progress", exp_pc, 32'(44 + 4 * (10 - LAT)));

    // Redirect with q_count=3 and a response in flight, back-to-back, last wins
    bus.inst_ready = 1'b0; #1;
    guard = 0;
    while (!(bus.q_count == 3'd3 && bus.imem_resp_valid) && guard < 8) begin
      tick();
      guard++;
    end
    check("e_setup_q3", 32'(bus.q_count), 32'd3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; #1;
    check("e_redir_req", 32'(bus.imem_req_valid), 32'd0);
    check("e_redir_inst", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.redirect_pc = 32'h103; #1;
    check("e_cleared", 32'(bus.q_count), 32'd0);
    check("e_redir2_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1; exp_pc = 32'h100; #1;
    check("e_x1_q", 32'(bus.q_count), 32'd0);
    check("e_x1_inst", 32'(bus.inst_valid), 32'd0);
    check("e_x1_req", 32'(bus.imem_req_valid), 32'd1);
    check("e_x1_addr", bus.imem_req_addr, 32'h100);
    tick();
    check("e_x2_inst", 32'(bus.inst_valid), 32'(LAT == 1));
    tick();
    check("e_x3_inst", 32'(bus.inst_valid), 32'd1);
    check("e_x3_pc", bus.inst_pc, 32'h100 + 32'(4 * (2 - LAT)));
    for (int i = 0; i < 6; i++) tick();
    check("e_progress", exp_pc, 32'h100 + 32'(4 * (8 - LAT)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
